// File: rtl/thrfsm_hang_wdog.sv
// Per-core thread-wait watchdog: times consecutive WAIT cycles on four threads and reports hangs
// one record at a time over a valid/ack handshake. Optional stats: THRFSM_WDOG_STATS_EN.
`ifndef THRFSM_WAIT
`define THRFSM_WAIT 5'b00100
`endif

module thrfsm_hang_wdog #(
    parameter int CNT_W = 16,
    parameter int TOT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic [4:0]           thr_state0,
    input  logic [4:0]           thr_state1,
    input  logic [4:0]           thr_state2,
    input  logic [4:0]           thr_state3,
    input  logic [3:0]           wm_imiss,
    input  logic [3:0]           wm_other,
    input  logic [3:0]           wm_stbwait,
    input  logic [3:0]           completion,
    input  logic [CNT_W-1:0]     cfg_timeout,
    input  logic                 hang_ack,
    output logic                 hang_vld,
    output logic [1:0]           hang_tid,
    output logic [2:0]           hang_cause,
    output logic [CNT_W-1:0]     hang_cnt,
    output logic [TOT_W-1:0]     hang_total,
    output logic [4*CNT_W-1:0]   max_wait
);

    // Handshake: a record is presented while hang_vld=1 and held stable until the posedge
    // at which hang_ack=1; that same edge may load the next record (one record per cycle max).
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAITING = 2'd1,
        S_PEND    = 2'd2,
        S_RPT     = 2'd3
    } thr_st_e;

    thr_st_e          st_q [4];
    thr_st_e          st_d [4];
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [4:0]       thr_state [4];
    logic [3:0]       wait_mask;
    logic [3:0]       waiting;
    logic [3:0]       tmo_hit;
    logic [3:0]       eligible;
    logic             tmo_en;
    logic             can_grant;
    logic             gnt_vld;
    logic [1:0]       gnt_tid;
    logic [1:0]       rr_q;
    logic             vld_q;
    logic [1:0]       tid_q;
    logic [2:0]       cause_q;
    logic [CNT_W-1:0] hcnt_q;
    logic [TOT_W-1:0] total_q;

    assign thr_state[0] = thr_state0;
    assign thr_state[1] = thr_state1;
    assign thr_state[2] = thr_state2;
    assign thr_state[3] = thr_state3;
    assign wait_mask    = wm_imiss | wm_other | wm_stbwait;
    assign tmo_en       = (cfg_timeout != '0);
    assign can_grant    = ~vld_q | hang_ack;

    always_comb begin
        waiting  = '0;
        tmo_hit  = '0;
        eligible = '0;
        for (int t = 0; t < 4; t++) begin
            waiting[t]  = (thr_state[t] == `THRFSM_WAIT) && wait_mask[t] && !completion[t];
            // Compare the post-increment count so PEND is reached on the threshold-th cycle.
            tmo_hit[t]  = tmo_en &&
                          (({1'b0, cnt_q[t]} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, cfg_timeout});
            eligible[t] = (st_q[t] == S_PEND) && waiting[t] && tmo_en;
            if (!waiting[t])
                cnt_d[t] = '0;
            else if (&cnt_q[t])
                cnt_d[t] = cnt_q[t];
            else
                cnt_d[t] = cnt_q[t] + CNT_W'(1);
        end
    end

    // Round-robin search starting one past the last granted thread.
    always_comb begin
        logic [1:0] idx;
        gnt_vld = 1'b0;
        gnt_tid = rr_q;
        idx     = '0;
        if (can_grant) begin
            for (int i = 1; i <= 4; i++) begin
                idx = rr_q + 2'(i);
                if (!gnt_vld && eligible[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_tid = idx;
                end
            end
        end
    end

    always_comb begin
        for (int t = 0; t < 4; t++) begin
            st_d[t] = st_q[t];
            case (st_q[t])
                S_IDLE: begin
                    if (waiting[t]) st_d[t] = S_WAITING;
                end
                S_WAITING: begin
                    if (!waiting[t])     st_d[t] = S_IDLE;
                    else if (tmo_hit[t]) st_d[t] = S_PEND;
                end
                S_PEND: begin
                    if (!waiting[t])                        st_d[t] = S_IDLE;
                    else if (!tmo_en)                       st_d[t] = S_WAITING;
                    else if (gnt_vld && gnt_tid == 2'(t))   st_d[t] = S_RPT;
                end
                S_RPT: begin
                    // A record already on the bus pins its thread here until accepted.
                    if (!waiting[t] && !(vld_q && tid_q == 2'(t))) st_d[t] = S_IDLE;
                end
                default: st_d[t] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int t = 0; t < 4; t++) begin
                st_q[t]  <= S_IDLE;
                cnt_q[t] <= '0;
            end
            rr_q    <= '0;
            vld_q   <= 1'b0;
            tid_q   <= '0;
            cause_q <= '0;
            hcnt_q  <= '0;
            total_q <= '0;
        end else begin
            for (int t = 0; t < 4; t++) begin
                st_q[t]  <= st_d[t];
                cnt_q[t] <= cnt_d[t];
            end
            if (gnt_vld) begin
                vld_q   <= 1'b1;
                tid_q   <= gnt_tid;
                cause_q <= {wm_stbwait[gnt_tid], wm_other[gnt_tid], wm_imiss[gnt_tid]};
                hcnt_q  <= cnt_q[gnt_tid];
                rr_q    <= gnt_tid;
                if (!(&total_q)) total_q <= total_q + TOT_W'(1);
            end else if (hang_ack) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign hang_vld   = vld_q;
    assign hang_tid   = tid_q;
    assign hang_cause = cause_q;
    assign hang_cnt   = hcnt_q;
    assign hang_total = total_q;

`ifdef THRFSM_WDOG_STATS_EN
    // Tracks the length of the longest WAIT run, i.e. the count including the current cycle.
    logic [CNT_W-1:0] mw_q [4];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int t = 0; t < 4; t++) mw_q[t] <= '0;
        end else begin
            for (int t = 0; t < 4; t++)
                if (waiting[t] && cnt_d[t] > mw_q[t]) mw_q[t] <= cnt_d[t];
        end
    end

    assign max_wait = {mw_q[3], mw_q[2], mw_q[1], mw_q[0]};
`else
    assign max_wait = '0;
`endif

endmodule

// File: tb/tb_thrfsm_hang_wdog.sv
// Directed bench for thrfsm_hang_wdog: expected hang records are queued by the stimulus
// and popped by a monitor at each accepted handshake.
`ifndef THRFSM_WAIT
`define THRFSM_WAIT 5'b00100
`endif

module tb_thrfsm_hang_wdog;
  localparam int CNT_W = 16;
  localparam int TOT_W = 8;
  localparam int RW    = 2 + 3 + CNT_W + TOT_W;
  localparam logic [4:0] ST_RDY = 5'b00001;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]         st [4];
  logic [3:0]         wm_imiss, wm_other, wm_stbwait, completion;
  logic [CNT_W-1:0]   cfg_timeout;
  logic               hang_ack;
  logic               hang_vld;
  logic [1:0]         hang_tid;
  logic [2:0]         hang_cause;
  logic [CNT_W-1:0]   hang_cnt;
  logic [TOT_W-1:0]   hang_total;
  logic [4*CNT_W-1:0] max_wait;

  thrfsm_hang_wdog #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .clk(clk), .rst_l(rst_l),
    .thr_state0(st[0]), .thr_state1(st[1]), .thr_state2(st[2]), .thr_state3(st[3]),
    .wm_imiss(wm_imiss), .wm_other(wm_other), .wm_stbwait(wm_stbwait),
    .completion(completion), .cfg_timeout(cfg_timeout), .hang_ack(hang_ack),
    .hang_vld(hang_vld), .hang_tid(hang_tid), .hang_cause(hang_cause),
    .hang_cnt(hang_cnt), .hang_total(hang_total), .max_wait(max_wait)
  );

  logic [RW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int vld_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rec(input logic [1:0] tid, input logic [2:0] cause,
                                        input logic [CNT_W-1:0] cnt, input logic [TOT_W-1:0] tot);
    return {tid, cause, cnt, tot};
  endfunction

  // Monitor: every accepted record must match the head of the expected queue.
  initial begin
    logic [RW-1:0] exp;
    forever begin
      @(negedge clk);
      if (rst_l && hang_vld && hang_ack) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_record: got tid=%0d cause=%0b cnt=%0d expected none",
                   hang_tid, hang_cause, hang_cnt);
        end else begin
          exp = exp_q.pop_front();
          check("record", 64'({hang_tid, hang_cause, hang_cnt, hang_total}), 64'(exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (hang_vld) vld_cycles++;
    end
  endtask

  task automatic idle_all();
    for (int t = 0; t < 4; t++) st[t] = ST_RDY;
    wm_imiss = '0; wm_other = '0; wm_stbwait = '0; completion = '0;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    idle_all();
    hang_ack = 1'b0;
    tick(2);
    rst_l = 1'b1;
  endtask

  task automatic set_thr(input int t, input logic [2:0] cause);
    st[t] = `THRFSM_WAIT;
    wm_stbwait[t] = cause[2];
    wm_other[t]   = cause[1];
    wm_imiss[t]   = cause[0];
  endtask

  task automatic clr_thr(input int t);
    st[t] = ST_RDY;
    wm_stbwait[t] = 1'b0; wm_other[t] = 1'b0; wm_imiss[t] = 1'b0;
  endtask

  initial begin
    logic [4*CNT_W-1:0] mw_exp;
    idle_all();
    cfg_timeout = '0;
    hang_ack = 1'b0;
    #1;
    check("rst_vld", 64'(hang_vld), 0);
    check("rst_tid", 64'(hang_tid), 0);
    check("rst_cause", 64'(hang_cause), 0);
    check("rst_cnt", 64'(hang_cnt), 0);
    check("rst_total", 64'(hang_total), 0);
    check("rst_max_wait", max_wait, 0);

    // T2 long wait: a single record, no re-report while it stays in WAIT.
    do_reset();
    cfg_timeout = 16'd8;
    hang_ack = 1'b1;
    exp_q.push_back(rec(2'd2, 3'b010, 16'd8, 8'd1));
    set_thr(2, 3'b010);
    tick(20);
    check("t1_vld_low", 64'(hang_vld), 0);
    check("t1_total", 64'(hang_total), 1);
    clr_thr(2);
    tick(2);

    // T1 waits one short of the threshold twice; the counter must restart in between.
    do_reset();
    cfg_timeout = 16'd8;
    hang_ack = 1'b1;
    vld_cycles = 0;
    set_thr(1, 3'b001);
    tick(7);
    clr_thr(1);
    tick(1);
    set_thr(1, 3'b001);
    tick(7);
    clr_thr(1);
    tick(3);
    check("t2_no_vld", 64'(vld_cycles), 0);
    check("t2_total", 64'(hang_total), 0);

    // T0, T1, T3 time out together; round-robin from rr=0 gives 1, 3, 0.
    do_reset();
    cfg_timeout = 16'd8;
    hang_ack = 1'b0;
    exp_q.push_back(rec(2'd1, 3'b100, 16'd8, 8'd1));
    exp_q.push_back(rec(2'd3, 3'b011, 16'd14, 8'd2));
    exp_q.push_back(rec(2'd0, 3'b001, 16'd15, 8'd3));
    set_thr(0, 3'b001);
    set_thr(1, 3'b100);
    set_thr(3, 3'b011);
    tick(9);
    for (int i = 0; i < 5; i++) begin
      check("t3_stable", 64'({hang_vld, hang_tid, hang_cause, hang_cnt}),
            64'({1'b1, 2'd1, 3'b100, 16'd8}));
      tick(1);
    end
    hang_ack = 1'b1;
    tick(3);
    check("t3_vld_low", 64'(hang_vld), 0);
    check("t3_total", 64'(hang_total), 3);
    idle_all();
    tick(2);

    // T3 goes PEND behind an unacked T0 record, then leaves WAIT: dropped.
    do_reset();
    cfg_timeout = 16'd8;
    hang_ack = 1'b0;
    exp_q.push_back(rec(2'd0, 3'b001, 16'd8, 8'd1));
    set_thr(0, 3'b001);
    tick(2);
    set_thr(3, 3'b010);
    tick(10);
    clr_thr(3);
    tick(1);
    hang_ack = 1'b1;
    tick(2);
    check("t4_vld_low", 64'(hang_vld), 0);
    check("t4_total", 64'(hang_total), 1);
    idle_all();
    tick(2);

    // Asynchronous reset while a record is pending.
    do_reset();
    cfg_timeout = 16'd4;
    hang_ack = 1'b0;
    set_thr(1, 3'b100);
    tick(6);
    check("t5_vld_before", 64'(hang_vld), 1);
    check("t5_tid_before", 64'(hang_tid), 1);
    rst_l = 1'b0;
    #1;
    check("t5_vld_rst", 64'(hang_vld), 0);
    check("t5_total_rst", 64'(hang_total), 0);
    check("t5_cnt_rst", 64'(hang_cnt), 0);
    check("t5_cause_rst", 64'(hang_cause), 0);
    hang_ack = 1'b1;
    exp_q.push_back(rec(2'd1, 3'b100, 16'd4, 8'd1));
    @(negedge clk);
    rst_l = 1'b1;
    tick(8);
    check("t5_vld_low", 64'(hang_vld), 0);
    check("t5_total", 64'(hang_total), 1);
    idle_all();
    tick(2);

    // Detection disabled; stats keep the longest run.
    do_reset();
    cfg_timeout = '0;
    hang_ack = 1'b1;
    vld_cycles = 0;
    set_thr(2, 3'b010);
    tick(30);
    clr_thr(2);
    tick(2);
    set_thr(2, 3'b010);
    tick(12);
    clr_thr(2);
    tick(2);
    check("t6_no_vld", 64'(vld_cycles), 0);
    mw_exp = '0;
`ifdef THRFSM_WDOG_STATS_EN
    mw_exp[2*CNT_W +: CNT_W] = 16'd30;
`endif
    check("t6_max_wait", max_wait, mw_exp);

    tick(2);
    check("queue_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
